// File: rtl/data_mem_arbiter_if.sv
// Requester-side bundle for one data_mem_arbiter port (CPU load/store or debug/loader).
// The requester drives the request fields; the arbiter answers with gnt and later rvalid/rdata.
interface data_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
);
  // Handshake: req acts as valid and gnt as ready, and a transfer happens on any cycle
  // with req && gnt. The requester holds req, we, addr, wdata and lock stable until it
  // sees gnt. On the next cycle it either drops req or presents a new request. A granted
  // read returns exactly one rvalid pulse one cycle later. A write has no response.
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  lock;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata, lock,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, lock,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter with per-port lock in front of the single-port data memory.
// Defining MEM_ARB_FIXED_PRIO_EN makes port A always win contention and drops the prio register.
module data_mem_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_arbiter_if.slave     port_a,
  data_mem_arbiter_if.slave     port_b,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            state_dbg
);

  localparam logic [1:0] ARB    = 2'd0;
  localparam logic [1:0] LOCK_A = 2'd1;
  localparam logic [1:0] LOCK_B = 2'd2;

  logic [1:0] state;
  logic [1:0] rd_owner;
  logic       gnt_a;
  logic       gnt_b;
  logic       favour_b;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign favour_b = 1'b0;
`else
  logic prio;

  // prio moves only on grants issued in ARB; it stays frozen while a lock is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (state == ARB && (gnt_a || gnt_b)) begin
      prio <= gnt_a;
    end
  end

  assign favour_b = prio;
`endif

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst) begin
      case (state)
        ARB: begin
          if (port_a.req && (!port_b.req || !favour_b)) begin
            gnt_a = 1'b1;
          end else if (port_b.req) begin
            gnt_b = 1'b1;
          end
        end
        LOCK_A:  gnt_a = port_a.req;
        LOCK_B:  gnt_b = port_b.req;
        default: ;
      endcase
    end
  end

  // The lock owner is still served on the cycle it drops lock; the other port waits one more cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB;
    end else begin
      case (state)
        ARB: begin
          if (gnt_a && port_a.lock) begin
            state <= LOCK_A;
          end else if (gnt_b && port_b.lock) begin
            state <= LOCK_B;
          end
        end
        LOCK_A:  if (!port_a.lock) state <= ARB;
        LOCK_B:  if (!port_b.lock) state <= ARB;
        default: state <= ARB;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    if (gnt_a) begin
      mem_addr  = port_a.addr;
      mem_wdata = port_a.wdata;
      mem_rd_en = ~port_a.we;
      mem_wr_en = port_a.we;
    end else if (gnt_b) begin
      mem_addr  = port_b.addr;
      mem_wdata = port_b.wdata;
      mem_rd_en = ~port_b.we;
      mem_wr_en = port_b.we;
    end
  end

  // rd_owner tracks the memory's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner <= 2'b00;
    end else begin
      rd_owner <= {gnt_b & ~port_b.we, gnt_a & ~port_a.we};
    end
  end

  // Gating with rst drops a read already in flight when reset lands on its return cycle.
  assign port_a.gnt    = gnt_a;
  assign port_b.gnt    = gnt_b;
  assign port_a.rvalid = rd_owner[0] & ~rst;
  assign port_b.rvalid = rd_owner[1] & ~rst;
  assign port_a.rdata  = mem_rdata;
  assign port_b.rdata  = mem_rdata;
  assign state_dbg     = state;

endmodule
